// File: rtl/psum_pkg.sv
// Shared defaults and state encoding for the partial-sum accumulator.
package psum_pkg;

  localparam int unsigned DefProdW = 16;
  localparam int unsigned DefAccW  = 24;
  localparam int unsigned DefOutW  = 8;
  localparam int unsigned DefLenW  = 8;
  localparam int unsigned ShiftW   = 5;

  // StAccum: collecting products; StHold: result presented on the output
  typedef enum logic [0:0] {
    StAccum = 1'b0,
    StHold  = 1'b1
  } psum_state_e;

endpackage

// File: rtl/psum_requant.sv
// Combinational requantiser: right shift followed by unsigned saturation.
module psum_requant
  import psum_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW,
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic [ACC_W-1:0]  psum,
  input  logic [ShiftW-1:0] shift,
  output logic [OUT_W-1:0]  q
);

  localparam logic [ACC_W-1:0] QMax = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [ACC_W-1:0] shifted;

  // Shift, then clamp to the largest representable activation
  always_comb begin
    shifted = psum >> shift;
    q       = (shifted > QMax) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/psum_accumulator.sv
// Windowed accumulator for PE products with valid/ready on both sides and a
// requantised copy of each window sum.
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int unsigned PROD_W = DefProdW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] product_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic [ShiftW-1:0] shift,
  input  logic              clear,
  output logic [ACC_W-1:0]  psum_out,
  output logic [OUT_W-1:0]  q_out,
  output logic              out_valid,
  input  logic              out_ready
);

  psum_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ShiftW-1:0] shift_q, shift_d;
  logic [ACC_W-1:0]  psum_q, psum_d;
  logic [OUT_W-1:0]  q_q, q_d;

  logic              first;
  logic              accept;
  logic              win_done;
  logic [LEN_W-1:0]  len_eff;
  logic [ShiftW-1:0] shift_eff;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  sum_next;
  logic [LEN_W-1:0]  cnt_next;
  logic [OUT_W-1:0]  q_next;

  // Datapath for the product offered this cycle; a product taken in HOLD
  // always opens a fresh window
  always_comb begin
    in_ready  = (state_q == StAccum) || ((state_q == StHold) && out_ready);
    accept    = in_valid && in_ready && !clear;
    first     = (state_q == StHold) || (cnt_q == '0);
    len_eff   = first ? ((acc_len == '0) ? LEN_W'(1) : acc_len) : len_q;
    shift_eff = first ? shift : shift_q;
    prod_ext  = {{(ACC_W-PROD_W){1'b0}}, product_in};
    sum_next  = first ? prod_ext : (acc_q + prod_ext);
    cnt_next  = first ? LEN_W'(1) : (cnt_q + LEN_W'(1));
    win_done  = (cnt_next == len_eff);
  end

  psum_requant #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_requant (
    .psum  (sum_next),
    .shift (shift_eff),
    .q     (q_next)
  );

  // Next-state: clear wins, then drain, then product acceptance
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    shift_d = shift_q;
    psum_d  = psum_q;
    q_d     = q_q;
    if (clear) begin
      state_d = StAccum;
      acc_d   = '0;
      cnt_d   = '0;
      psum_d  = '0;
      q_d     = '0;
    end else begin
      unique case (state_q)
        StHold:  if (out_ready) state_d = StAccum;
        default: state_d = state_q;
      endcase
      if (accept) begin
        len_d   = len_eff;
        shift_d = shift_eff;
        acc_d   = sum_next;
        if (win_done) begin
          // cnt back to 0 so the next accepted product starts a new window
          state_d = StHold;
          cnt_d   = '0;
          psum_d  = sum_next;
          q_d     = q_next;
        end else begin
          cnt_d   = cnt_next;
        end
      end
    end
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      shift_q <= '0;
      psum_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      shift_q <= shift_d;
      psum_q  <= psum_d;
      q_q     <= q_d;
    end
  end

  // Result is registered so it stays put while the consumer stalls
  always_comb begin
    out_valid = (state_q == StHold);
    psum_out  = psum_q;
    q_out     = q_q;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator using a scoreboard of window results.
module tb_psum_accumulator;

  logic        clk;
  logic        rst_n;
  logic [15:0] product_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  acc_len;
  logic [4:0]  shift;
  logic        clear;
  logic [23:0] psum_out;
  logic [7:0]  q_out;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [23:0] psum;
    logic [7:0]  q;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_hs  = 0;

  psum_accumulator dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .product_in (product_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc_len    (acc_len),
    .shift      (shift),
    .clear      (clear),
    .psum_out   (psum_out),
    .q_out      (q_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output handshakes to catch extra or missing results
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) n_hs <= n_hs + 1;
  end

  function automatic logic [7:0] model_q(input logic [23:0] s, input int sh);
    logic [23:0] v;
    v = s >> sh;
    return (v > 24'd255) ? 8'hff : v[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and wait (bounded) until it is taken
  task automatic send(input logic [15:0] p);
    int budget;
    budget     = 50;
    product_in = p;
    in_valid   = 1'b1;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    end
    n_cmp++;
    if (psum_out !== 24'd0 || q_out !== 8'd0) begin
      n_err++; $display("FAIL reset_outputs: got %0d/%0d want 0/0", psum_out, q_out);
    end
  endtask

  // Products k*(k+1), k=1..8, back-to-back; result checked one cycle after the last
  task automatic test_window(input int sh);
    logic [23:0] sum;
    exp_t        e;
    int          hs0;
    sum       = '0;
    acc_len   = 8'd8;
    shift     = 5'(sh);
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) sum += 24'(k * (k + 1));
    sb.push_back('{psum: sum, q: model_q(sum, sh)});
    for (int k = 1; k <= 8; k++) send(16'(k * (k + 1)));
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL window_sh%0d_latency: out_valid %0b want 1", sh, out_valid);
    end
    n_cmp++;
    if (psum_out !== e.psum) begin
      n_err++; $display("FAIL window_sh%0d_psum: got %0d want %0d", sh, psum_out, e.psum);
    end
    n_cmp++;
    if (q_out !== e.q) begin
      n_err++; $display("FAIL window_sh%0d_q: got %0d want %0d", sh, q_out, e.q);
    end
    hs0       = n_hs;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || n_hs !== hs0 + 1) begin
      n_err++;
      $display("FAIL window_sh%0d_drain: valid %0b hs %0d want 0 %0d", sh, out_valid, n_hs,
               hs0 + 1);
    end
  endtask

  task automatic test_saturate();
    exp_t e;
    acc_len   = 8'd3;
    shift     = 5'd8;
    out_ready = 1'b0;
    sb.push_back('{psum: 24'd196605, q: 8'd255});
    repeat (3) send(16'hffff);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || psum_out !== e.psum || q_out !== e.q) begin
      n_err++;
      $display("FAIL saturate: got v%0b %0d/%0d want v1 %0d/%0d", out_valid, psum_out, q_out,
               e.psum, e.q);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   hs0;
    acc_len   = 8'd2;
    shift     = 5'd0;
    out_ready = 1'b0;
    sb.push_back('{psum: 24'd30, q: 8'd30});
    send(16'd10);
    send(16'd20);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || psum_out !== e.psum || q_out !== e.q) begin
        n_err++;
        $display("FAIL stall_cycle%0d: v%0b rdy%0b %0d/%0d want v1 rdy0 %0d/%0d", i, out_valid,
                 in_ready, psum_out, q_out, e.psum, e.q);
      end
      tick();
    end
    hs0 = n_hs;
    sb.push_back('{psum: 24'd7, q: 8'd7});
    out_ready  = 1'b1;
    product_in = 16'd3;
    in_valid   = 1'b1;
    tick();
    n_cmp++;
    if (n_hs !== hs0 + 1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_and_start: hs %0d v%0b want %0d v0", n_hs, out_valid, hs0 + 1);
    end
    product_in = 16'd4;
    tick();
    in_valid = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || psum_out !== e.psum) begin
      n_err++; $display("FAIL nobubble_result: v%0b %0d want v1 %0d", out_valid, psum_out, e.psum);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_len_zero();
    exp_t e;
    int   hs0;
    acc_len   = 8'd0;
    shift     = 5'd0;
    out_ready = 1'b1;
    hs0       = n_hs;
    sb.push_back('{psum: 24'd5, q: 8'd5});
    sb.push_back('{psum: 24'd7, q: 8'd7});
    send(16'd5);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || psum_out !== e.psum || q_out !== e.q) begin
      n_err++; $display("FAIL len0_first: v%0b %0d want v1 %0d", out_valid, psum_out, e.psum);
    end
    send(16'd7);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || psum_out !== e.psum || q_out !== e.q) begin
      n_err++; $display("FAIL len0_second: v%0b %0d want v1 %0d", out_valid, psum_out, e.psum);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || n_hs !== hs0 + 2) begin
      n_err++; $display("FAIL len0_beats: v%0b hs %0d want v0 %0d", out_valid, n_hs, hs0 + 2);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    exp_t e;
    int   hs0;
    acc_len   = 8'd8;
    shift     = 5'd0;
    out_ready = 1'b1;
    hs0       = n_hs;
    repeat (4) send(16'd9);
    clear      = 1'b1;
    product_in = 16'd100;
    in_valid   = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL clear_valid: got %0b want 0", out_valid);
    end
    sb.push_back('{psum: 24'd8, q: 8'd8});
    repeat (8) send(16'd1);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || psum_out !== e.psum) begin
      n_err++; $display("FAIL clear_result: v%0b %0d want v1 %0d", out_valid, psum_out, e.psum);
    end
    tick();
    n_cmp++;
    if (n_hs !== hs0 + 1) begin
      n_err++; $display("FAIL clear_count: hs %0d want %0d", n_hs, hs0 + 1);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   hs0;
    hs0       = n_hs;
    acc_len   = 8'd8;
    shift     = 5'd0;
    out_ready = 1'b1;
    repeat (3) send(16'd11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || psum_out !== 24'd0 || q_out !== 8'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_window: v%0b %0d/%0d rdy%0b want v0 0/0 rdy1", out_valid, psum_out,
               q_out, in_ready);
    end
    acc_len   = 8'd1;
    out_ready = 1'b0;
    send(16'd50);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (out_valid !== 1'b0 || psum_out !== 24'd0 || n_hs !== hs0) begin
      n_err++;
      $display("FAIL rst_in_hold: v%0b %0d hs %0d want v0 0 %0d", out_valid, psum_out, n_hs, hs0);
    end
    acc_len   = 8'd2;
    out_ready = 1'b1;
    sb.push_back('{psum: 24'd3, q: 8'd3});
    send(16'd1);
    send(16'd2);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || psum_out !== e.psum) begin
      n_err++; $display("FAIL rst_recover: v%0b %0d want v1 %0d", out_valid, psum_out, e.psum);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    product_in = '0;
    in_valid   = 1'b0;
    acc_len    = '0;
    shift      = '0;
    clear      = 1'b0;
    out_ready  = 1'b0;
    test_reset();
    test_window(0);
    test_window(4);
    test_saturate();
    test_back_to_back();
    test_len_zero();
    test_clear();
    test_reset_mid();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++; $display("FAIL scoreboard_left: %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 16, meaning width of one PE product.
REQ-002 SHALL have parameter ACC_W, default 24, meaning accumulator and psum_out width.
REQ-003 SHALL have parameter OUT_W, default 8, meaning requantised activation width.
REQ-004 SHALL have parameter LEN_W, default 8, meaning width of the window-length field.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-007 SHALL have port product_in, input, PROD_W, meaning the unsigned PE product_output.
REQ-008 SHALL have port in_valid, input, 1, meaning product_in is valid this cycle.
REQ-009 SHALL have port in_ready, output, 1, meaning a product is accepted when in_valid && in_ready.
REQ-010 SHALL have port acc_len, input, LEN_W, meaning the number of products per window.
REQ-011 SHALL have port shift, input, 5, meaning the right-shift amount for requantisation.
REQ-012 SHALL have port clear, input, 1, meaning a synchronous abort of the window.
REQ-013 SHALL have port psum_out, output, ACC_W, meaning the full window sum.
REQ-014 SHALL have port q_out, output, OUT_W, meaning the saturated result of psum_out >> shift.
REQ-015 SHALL have port out_valid, output, 1, meaning psum_out and q_out are valid.
REQ-016 SHALL have port out_ready, input, 1, meaning the consumer accepts when out_valid && out_ready.

Function
REQ-017 SHALL implement a two-state FSM: ACCUM (collecting products) and HOLD (result presented).
REQ-018 SHALL drive in_ready = (state==ACCUM) || (state==HOLD && out_ready).
REQ-019 SHALL latch acc_len and shift on the first accepted product of each window; changes mid-window are ignored.
REQ-020 SHALL treat a latched acc_len of 0 as 1.
REQ-021 SHALL load acc = product_in and cnt = 1 on the first product of a window, then acc += product_in and cnt++ on each later product.
REQ-022 SHALL zero-extend products with unsigned arithmetic; ACC_W=24 cannot overflow for 255 x 65535, so no wrap checking is needed.
REQ-023 SHALL, when the accepted product makes cnt equal the latched length, move to HOLD and assert out_valid on the next cycle (latency 1 from the last product).
REQ-024 SHALL hold psum_out, q_out and out_valid stable in HOLD until out_valid && out_ready.
REQ-025 SHALL compute q_out = min(psum_out >> shift, 2^OUT_W - 1).
REQ-026 SHALL, in HOLD with out_ready && in_valid in the same cycle, drain the result and start a new window with that product, with no bubble.
REQ-027 SHALL, when that new product also completes a window (length 1), remain in HOLD with the new result and keep out_valid high.
REQ-028 SHALL, in HOLD with out_ready && !in_valid, return to ACCUM and deassert out_valid.
REQ-029 SHALL give clear priority over all other events: discard the partial window and any held result, deassert out_valid, set cnt=0, enter ACCUM, and drop any product presented in that cycle.

Reset
REQ-030 SHALL, with rst_n low at a clock edge, set state=ACCUM, acc=0, cnt=0, psum_out=0, q_out=0 and out_valid=0.
REQ-031 SHALL, after reset, hold in_ready=1 and out_valid=0.
REQ-032 SHALL, on reset mid-window or in HOLD, lose the partial or held result without emitting it.

Structure
REQ-033 SHALL place PROD_W/ACC_W/OUT_W/LEN_W defaults and the ACCUM/HOLD state encoding in shared package psum_pkg.
REQ-034 SHALL implement the shift-and-saturate as the combinational sub-module psum_requant (ACC_W in, shift in, OUT_W out).
REQ-035 SHALL connect product_in directly to PE product_output, with no extra register stage.

Verification
REQ-036 SHALL cover: acc_len=8, shift=0, products 2,6,12,20,30,42,56,72 back-to-back -> one cycle after the last product, psum_out=240, q_out=240, out_valid=1.
REQ-037 SHALL cover: the same window with shift=4 -> psum_out=240, q_out=15.
REQ-038 SHALL cover: acc_len=3, shift=8, three products of 65535 -> psum_out=196605, q_out=255 (saturated).
REQ-039 SHALL cover: out_ready low for 5 cycles after completion -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> drain and new window start in the same cycle.
REQ-040 SHALL cover: acc_len=0 with products 5,7 -> two results, 5 then 7, each lasting one out_valid beat with out_ready=1.
REQ-041 SHALL cover: clear after 4 of 8 products, then 8 products of 1 -> a single result, psum_out=8; rst_n low mid-window -> no result emitted, outputs all 0.
